// File: rtl/roce_meta_arbiter.sv
// Round-robin merge of per-requester meta commands onto one RoCE tx meta stream.
// An issue-order FIFO steers the in-order completion status back to the issuing requester.
module roce_meta_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int C_META_WIDTH    = 256,
    parameter int C_STATUS_WIDTH  = 512,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ORDER_DEPTH     = 16
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            enable,
    input  logic [NUM_REQ-1:0]              s_axis_req_meta_tvalid,
    output logic [NUM_REQ-1:0]              s_axis_req_meta_tready,
    input  logic [NUM_REQ*C_META_WIDTH-1:0] s_axis_req_meta_tdata,
    output logic                            m_axis_tx_meta_tvalid,
    input  logic                            m_axis_tx_meta_tready,
    output logic [C_META_WIDTH-1:0]         m_axis_tx_meta_tdata,
    output logic [C_META_WIDTH/8-1:0]       m_axis_tx_meta_tkeep,
    output logic                            m_axis_tx_meta_tlast,
    input  logic                            s_axis_tx_status_tvalid,
    output logic                            s_axis_tx_status_tready,
    input  logic [C_STATUS_WIDTH-1:0]       s_axis_tx_status_tdata,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ*4-1:0]            req_outstanding,
    output logic                            arb_idle
);

    localparam int          IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          AW   = $clog2(ORDER_DEPTH);
    localparam int unsigned NREQ = NUM_REQ;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          last_grant_q;
    logic [IDW-1:0]          fifo_q [ORDER_DEPTH];
    logic [AW:0]             wr_ptr_q, rd_ptr_q;
    logic [3:0]              cnt_q [NUM_REQ];
    logic [3:0]              cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0]      done_q;
    logic [C_META_WIDTH-1:0] tdata_q;

    logic                    fifo_empty, fifo_full, push, pop, any_elig;
    logic [IDW-1:0]          head_id, winner;
    logic [NUM_REQ-1:0]      elig;
    logic                    unused_status;

    assign unused_status = ^s_axis_tx_status_tdata;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_id    = fifo_q[rd_ptr_q[AW-1:0]];

    assign s_axis_tx_status_tready = !fifo_empty && !areset;
    assign pop = s_axis_tx_status_tvalid && s_axis_tx_status_tready;

    // A completion landing this cycle frees a count slot and a FIFO slot for the same-cycle grant.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = s_axis_req_meta_tvalid[i] && enable && !areset
                   && ((cnt_q[i] < 4'(MAX_OUTSTANDING)) || (pop && head_id == IDW'(i)))
                   && (!fifo_full || pop);
        end
    end

    always_comb begin
        int unsigned idx;
        idx      = 0;
        any_elig = 1'b0;
        winner   = last_grant_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_grant_q) + k) % NREQ;
            if (!any_elig && elig[IDW'(idx)]) begin
                any_elig = 1'b1;
                winner   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_elig) state_d = S_SEND;
            S_SEND:  if (m_axis_tx_meta_tready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_req_meta_tready = '0;
        m_axis_tx_meta_tvalid  = 1'b0;
        push                   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    s_axis_req_meta_tready[winner] = 1'b1;
                    push = 1'b1;
                end
            end
            S_SEND:  m_axis_tx_meta_tvalid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i] + 4'(push && winner == IDW'(i)) - 4'(pop && head_id == IDW'(i));
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            last_grant_q <= IDW'(NUM_REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tdata_q      <= '0;
            done_q       <= '0;
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            done_q <= '0;
            if (push) begin
                last_grant_q <= winner;
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                tdata_q      <= s_axis_req_meta_tdata[int'(winner)*C_META_WIDTH +: C_META_WIDTH];
            end
            if (pop) begin
                rd_ptr_q        <= rd_ptr_q + 1'b1;
                done_q[head_id] <= 1'b1;
            end
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= winner;
    end

    always_comb begin
        req_outstanding = '0;
        for (int unsigned i = 0; i < NREQ; i++) req_outstanding[i*4 +: 4] = cnt_q[i];
    end

    assign req_done             = done_q;
    assign m_axis_tx_meta_tdata = tdata_q;
    assign m_axis_tx_meta_tkeep = '1;
    assign m_axis_tx_meta_tlast = 1'b1;
    assign arb_idle             = (state_q == S_IDLE) && fifo_empty && (req_outstanding == '0);

endmodule

// File: tb/tb_roce_meta_arbiter.sv
// Directed and randomized bench for roce_meta_arbiter against a queue-based model
// of grant order, outstanding counts and in-order completion routing.
module tb_roce_meta_arbiter;

    localparam int NR    = 2;
    localparam int MW    = 256;
    localparam int SW    = 512;
    localparam int MAXO  = 8;
    localparam int DEPTH = 16;

    logic              ap_clk = 1'b0;
    logic              areset, enable;
    logic [NR-1:0]     s_tvalid, s_tready;
    logic [NR*MW-1:0]  s_tdata;
    logic              m_tvalid, m_tready;
    logic [MW-1:0]     m_tdata;
    logic [MW/8-1:0]   m_tkeep;
    logic              m_tlast;
    logic              st_tvalid, st_tready;
    logic [SW-1:0]     st_tdata;
    logic [NR-1:0]     req_done;
    logic [NR*4-1:0]   req_out;
    logic              arb_idle;

    int checks = 0;
    int errors = 0;

    int            ord_q[$];
    int            cnt[NR];
    int            last_g;
    bit            sending;
    logic [MW-1:0] held;
    logic [NR-1:0] done_now;
    bit            p_grant, p_pop;
    int            p_win, p_head;

    always #5 ap_clk = ~ap_clk;

    roce_meta_arbiter #(
        .NUM_REQ        (NR),
        .C_META_WIDTH   (MW),
        .C_STATUS_WIDTH (SW),
        .MAX_OUTSTANDING(MAXO),
        .ORDER_DEPTH    (DEPTH)
    ) dut (
        .ap_clk                 (ap_clk),
        .areset                 (areset),
        .enable                 (enable),
        .s_axis_req_meta_tvalid (s_tvalid),
        .s_axis_req_meta_tready (s_tready),
        .s_axis_req_meta_tdata  (s_tdata),
        .m_axis_tx_meta_tvalid  (m_tvalid),
        .m_axis_tx_meta_tready  (m_tready),
        .m_axis_tx_meta_tdata   (m_tdata),
        .m_axis_tx_meta_tkeep   (m_tkeep),
        .m_axis_tx_meta_tlast   (m_tlast),
        .s_axis_tx_status_tvalid(st_tvalid),
        .s_axis_tx_status_tready(st_tready),
        .s_axis_tx_status_tdata (st_tdata),
        .req_done               (req_done),
        .req_outstanding        (req_out),
        .arb_idle               (arb_idle)
    );

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ord_q.delete();
        foreach (cnt[i]) cnt[i] = 0;
        last_g   = NR - 1;
        sending  = 0;
        held     = '0;
        done_now = '0;
    endtask

    task automatic new_data();
        for (int i = 0; i < NR*MW/32; i++) s_tdata[i*32 +: 32] = $urandom();
        for (int i = 0; i < SW/32; i++) st_tdata[i*32 +: 32] = $urandom();
    endtask

    task automatic predict_and_check();
        logic [NR-1:0]   exp_rdy;
        logic [NR*4-1:0] exp_out;
        int              qsz;
        qsz     = ord_q.size();
        p_pop   = st_tvalid && (qsz > 0);
        p_head  = p_pop ? ord_q[0] : -1;
        p_grant = 0;
        p_win   = 0;
        exp_rdy = '0;
        if (!sending) begin
            for (int k = 1; k <= NR; k++) begin
                int w;
                w = (last_g + k) % NR;
                if (!p_grant && s_tvalid[w] && enable && (cnt[w] < MAXO || p_head == w)
                    && (qsz < DEPTH || p_pop)) begin
                    p_grant = 1;
                    p_win   = w;
                end
            end
        end
        if (p_grant) exp_rdy[p_win] = 1'b1;
        exp_out = '0;
        for (int i = 0; i < NR; i++) exp_out[i*4 +: 4] = 4'(cnt[i]);
        chk("req_tready", s_tready, exp_rdy);
        chk("status_tready", st_tready, qsz > 0);
        chk("m_tvalid", m_tvalid, sending);
        chk("m_tdata", m_tdata, held);
        chk("req_done", req_done, done_now);
        chk("req_outstanding", req_out, exp_out);
        chk("arb_idle", arb_idle, !sending && qsz == 0);
        chk("tkeep", m_tkeep, {(MW/8){1'b1}});
        chk("tlast", m_tlast, 1'b1);
    endtask

    task automatic model_update();
        logic [NR-1:0] done_nxt;
        done_nxt = '0;
        if (p_pop) begin
            void'(ord_q.pop_front());
            cnt[p_head]--;
            done_nxt[p_head] = 1'b1;
        end
        if (p_grant) begin
            ord_q.push_back(p_win);
            cnt[p_win]++;
            last_g  = p_win;
            held    = s_tdata[p_win*MW +: MW];
            sending = 1;
        end else if (sending && m_tready) begin
            sending = 0;
        end
        done_now = done_nxt;
    endtask

    task automatic cycle();
        new_data();
        #1;
        predict_and_check();
        @(posedge ap_clk);
        model_update();
        @(negedge ap_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        areset = 1'b0;
        model_reset();
    endtask

    initial begin
        enable    = 1'b1;
        s_tvalid  = '0;
        m_tready  = 1'b0;
        st_tvalid = 1'b0;
        s_tdata   = '0;
        st_tdata  = '0;

        // reset state
        do_reset();
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, '0);
        chk("rst_counts", req_out, '0);
        chk("rst_idle", arb_idle, 1'b1);
        chk("rst_done", req_done, '0);
        run(2);

        // alternating grants until both requesters are capped
        s_tvalid = 2'b11;
        m_tready = 1'b1;
        run(40);
        chk("capped_counts", req_out, 8'h88);
        chk("capped_not_idle", arb_idle, 1'b0);

        // three completions routed 0,1,0 then requester 0 wins again
        s_tvalid  = 2'b00;
        st_tvalid = 1'b1;
        run(3);
        st_tvalid = 1'b0;
        run(1);
        chk("counts_after_3", req_out, 8'h76);
        s_tvalid = 2'b11;
        #1;
        chk("rr_regain", s_tready, 2'b01);
        cycle();
        s_tvalid = 2'b00;
        run(3);

        // requester 0 at the cap, completion and grant in the same cycle
        do_reset();
        s_tvalid = 2'b01;
        m_tready = 1'b1;
        run(20);
        chk("req0_capped", req_out, 8'h08);
        st_tvalid = 1'b1;
        #1;
        chk("grant_with_pop", s_tready, 2'b01);
        cycle();
        st_tvalid = 1'b0;
        s_tvalid  = 2'b00;
        chk("count_stays_8", req_out, 8'h08);
        run(4);

        // backpressure on the merged stream
        do_reset();
        s_tvalid = 2'b10;
        m_tready = 1'b0;
        run(11);
        chk("held_tvalid", m_tvalid, 1'b1);
        m_tready = 1'b1;
        cycle();
        s_tvalid = 2'b00;
        run(2);

        // status with nothing outstanding
        do_reset();
        st_tvalid = 1'b1;
        run(5);
        chk("empty_status_counts", req_out, '0);
        st_tvalid = 1'b0;

        // reset in the middle of a send
        do_reset();
        s_tvalid = 2'b10;
        m_tready = 1'b0;
        run(2);
        s_tvalid = 2'b11;
        do_reset();
        chk("midsend_tvalid", m_tvalid, 1'b0);
        chk("midsend_counts", req_out, '0);
        chk("midsend_idle", arb_idle, 1'b1);
        #1;
        chk("post_reset_grant", s_tready, 2'b01);
        cycle();

        // random traffic: first build up outstanding work, then drain it harder
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s_tvalid  = NR'($urandom_range(0, 3));
            enable    = ($urandom_range(0, 7) != 0);
            m_tready  = ($urandom_range(0, 2) != 0);
            st_tvalid = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle();
        end
        s_tvalid  = '0;
        enable    = 1'b1;
        m_tready  = 1'b1;
        st_tvalid = 1'b1;
        run(24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
